// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the system RAM port arbiter, RAM and MDR blocks.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port synchronous-read system RAM.
// One access every four cycles; contention is resolved round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_ack_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  input  logic                  dma_req_i,
  input  logic                  dma_we_i,
  input  logic [ADDR_WIDTH-1:0] dma_addr_i,
  input  logic [DATA_WIDTH-1:0] dma_wdata_i,
  output logic                  dma_ack_o,
  output logic [DATA_WIDTH-1:0] dma_rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic                  ram_we_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  busy_o,
  output logic                  grant_dma_o
);

  arb_state_e            state_q;
  logic                  owner_q;
  logic                  we_q;
  logic                  cpu_ack_q;
  logic                  dma_ack_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  ram_we_q;

  logic                  any_req_d;
  logic                  owner_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // Round-robin pick: on contention the loser of the previous grant wins.
  always_comb begin
    any_req_d = cpu_req_i | dma_req_i;
    owner_d   = dma_req_i & (~cpu_req_i | (owner_q == OWN_CPU));
    we_d      = (owner_d == OWN_DMA) ? dma_we_i    : cpu_we_i;
    addr_d    = (owner_d == OWN_DMA) ? dma_addr_i  : cpu_addr_i;
    wdata_d   = (owner_d == OWN_DMA) ? dma_wdata_i : cpu_wdata_i;
  end

  // Transaction FSM; the async reset also kills an in-flight write strobe.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_DMA;
      we_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= {DATA_WIDTH{1'b0}};
      dma_rdata_q <= {DATA_WIDTH{1'b0}};
      ram_addr_q  <= {ADDR_WIDTH{1'b0}};
      ram_wdata_q <= {DATA_WIDTH{1'b0}};
      ram_we_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            owner_q     <= owner_d;
            we_q        <= we_d;
            ram_addr_q  <= addr_d;
            ram_wdata_q <= wdata_d;
            ram_we_q    <= we_d;
            state_q     <= ST_ACCESS;
          end else begin
            state_q     <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          ram_we_q <= 1'b0;
          state_q  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Read data arrives one cycle after the address edge.
          if (owner_q == OWN_DMA) begin
            dma_ack_q <= 1'b1;
            if (!we_q) begin
              dma_rdata_q <= ram_rdata_i;
            end
          end else begin
            cpu_ack_q <= 1'b1;
            if (!we_q) begin
              cpu_rdata_q <= ram_rdata_i;
            end
          end
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          ram_we_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack_o   = cpu_ack_q;
  assign dma_ack_o   = dma_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_we_o    = ram_we_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign grant_dma_o = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 512x32 RAM.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_ack, dma_ack;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          busy, grant_dma;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clock(Clock), .Reset(Reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we), .ram_rdata_i(ram_rdata),
    .busy_o(busy), .grant_dma_o(grant_dma)
  );

  always #5 Clock = ~Clock;

  // RAM model with a backdoor write port for preloading
  logic [DW-1:0] mem [0:511];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge Clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int            cpu_acks = 0, dma_acks = 0, we_cycles = 0, we_illegal = 0;
  logic [AW-1:0] we_addr_seen;
  int            ack_cyc[$];
  bit            ack_own[$];

  always @(negedge Clock) begin
    if (cpu_ack) begin cpu_acks <= cpu_acks + 1; ack_cyc.push_back(cyc); ack_own.push_back(1'b0); end
    if (dma_ack) begin dma_acks <= dma_acks + 1; ack_cyc.push_back(cyc); ack_own.push_back(1'b1); end
    if (ram_we) begin we_cycles <= we_cycles + 1; we_addr_seen <= ram_addr; end
    if (ram_we && !busy) we_illegal <= we_illegal + 1;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    tick();
  endtask

  // Issue one request, wait (bounded) for its ack, then drop the request.
  task automatic do_req(input bit use_dma, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat);
    if (use_dma) begin dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1; end
    else         begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
    lat = 0;
    while (lat < 20 && !(use_dma ? dma_ack : cpu_ack)) begin
      tick();
      lat++;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
  endtask

  int lat, a0, d0, w0;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    do_reset();

    check_val("rst_cpu_ack",   32'(cpu_ack), 32'd0);
    check_val("rst_dma_ack",   32'(dma_ack), 32'd0);
    check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_val("rst_dma_rdata", dma_rdata, 32'd0);
    check_val("rst_ram_addr",  32'(ram_addr), 32'd0);
    check_val("rst_ram_wdata", ram_wdata, 32'd0);
    check_val("rst_ram_we",    32'(ram_we), 32'd0);
    check_val("rst_busy",      32'(busy), 32'd0);
    check_val("rst_grant_dma", 32'(grant_dma), 32'd1);

    preload(9'h010, 32'h1234ABCD);
    preload(9'h020, 32'hA5A5_0020);
    preload(9'h021, 32'h5A5A_0021);
    preload(9'h030, 32'h0BAD_F00D);
    preload(9'h040, 32'h0000_0099);

    // Single CPU read
    a0 = cpu_acks; d0 = dma_acks;
    do_req(1'b0, 1'b0, 9'h010, 32'h0, lat);
    check_val("rd_lat",     32'(lat), 32'd3);
    check_val("rd_data",    cpu_rdata, 32'h1234ABCD);
    check_val("rd_ack_one", 32'(cpu_acks - a0), 32'd1);
    check_val("rd_no_dma",  32'(dma_acks - d0), 32'd0);
    check_val("rd_ack_low", 32'(cpu_ack), 32'd0);

    // DMA write then CPU read-back
    w0 = we_cycles;
    do_req(1'b1, 1'b1, 9'h1FF, 32'hDEADBEEF, lat);
    check_val("dw_lat",      32'(lat), 32'd3);
    check_val("dw_we_once",  32'(we_cycles - w0), 32'd1);
    check_val("dw_we_addr",  32'(we_addr_seen), 32'h1FF);
    check_val("dw_mem",      mem[9'h1FF], 32'hDEADBEEF);
    check_val("dw_dma_rd",   dma_rdata, 32'd0);
    check_val("dw_grant",    32'(grant_dma), 32'd1);
    do_req(1'b0, 1'b0, 9'h1FF, 32'h0, lat);
    check_val("dw_cpu_rd",   cpu_rdata, 32'hDEADBEEF);
    check_val("dw_dma_keep", dma_rdata, 32'd0);

    // Contention from reset: both hold reads continuously
    do_reset();
    ack_cyc.delete(); ack_own.delete();
    cpu_we = 1'b0; cpu_addr = 9'h020; dma_we = 1'b0; dma_addr = 9'h021;
    cpu_req = 1'b1; dma_req = 1'b1;
    repeat (16) tick();
    cpu_req = 1'b0; dma_req = 1'b0;
    tick(); tick();
    check_val("rr_count", 32'(ack_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_cyc.size()) begin
        check_val($sformatf("rr_owner%0d", i), 32'(ack_own[i]), 32'(i % 2));
        if (i > 0) check_val($sformatf("rr_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
      end
    end
    check_val("rr_cpu_data", cpu_rdata, 32'hA5A5_0020);
    check_val("rr_dma_data", dma_rdata, 32'h5A5A_0021);

    // CPU streams reads, DMA requests once mid-transaction
    do_reset();
    cpu_we = 1'b0; cpu_addr = 9'h010; cpu_req = 1'b1;
    tick(); tick();
    dma_we = 1'b0; dma_addr = 9'h021; dma_req = 1'b1;
    lat = 0;
    while (lat < 20 && !dma_ack) begin tick(); lat++; end
    dma_req = 1'b0;
    check_val("bb_dma_lat",  32'(lat), 32'd5);
    check_val("bb_dma_data", dma_rdata, 32'h5A5A_0021);
    lat = 0;
    while (lat < 20 && !cpu_ack) begin tick(); lat++; end
    cpu_req = 1'b0;
    check_val("bb_cpu_next", 32'(lat), 32'd4);
    tick(); tick();

    // Reset during ACCESS of a CPU write
    a0 = cpu_acks;
    cpu_we = 1'b1; cpu_addr = 9'h030; cpu_wdata = 32'h1111_1111; cpu_req = 1'b1;
    tick();
    check_val("rw_we_set", 32'(ram_we), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check_val("rw_we_drop", 32'(ram_we), 32'd0);
    check_val("rw_busy",    32'(busy), 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    Reset = 1'b0;
    tick(); tick(); tick();
    check_val("rw_mem",    mem[9'h030], 32'h0BAD_F00D);
    check_val("rw_no_ack", 32'(cpu_acks - a0), 32'd0);
    check_val("rw_idle",   32'(busy), 32'd0);

    // Write does not disturb last read data
    do_req(1'b0, 1'b0, 9'h040, 32'h0, lat);
    check_val("wk_rd", cpu_rdata, 32'h0000_0099);
    a0 = cpu_acks;
    do_req(1'b0, 1'b1, 9'h041, 32'h0000_0055, lat);
    check_val("wk_lat",  32'(lat), 32'd3);
    check_val("wk_ack",  32'(cpu_acks - a0), 32'd1);
    check_val("wk_keep", cpu_rdata, 32'h0000_0099);
    check_val("wk_mem",  mem[9'h041], 32'h0000_0055);

    check_val("we_only_busy", 32'(we_illegal), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port, synchronous-read system RAM between two requesters: the CPU memory path (MDR load/fetch and store via RAM_write) and a DMA/program-loader port. A 4-state FSM serialises accesses. Simultaneous requests are resolved round-robin. Each requester sees a level-request / one-cycle-ack handshake, so neither needs to know the other exists.

## Interface
- ADDR_WIDTH, 9, word address width; 512 x 32 RAM
- DATA_WIDTH, 32, data width
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  reset Reset, asynchronous, active-high; clock Clock
- cpu_req  in  1  CPU request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_WIDTH  CPU word address; stable while cpu_req
- cpu_wdata  in  DATA_WIDTH  CPU write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read result; valid while cpu_ack, held until next CPU read completes
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same directions, widths and meaning as the cpu_ ports, for the DMA requester
- ram_addr  out  ADDR_WIDTH  registered RAM address
- ram_wdata  out  DATA_WIDTH  registered RAM write data
- ram_we  out  1  registered RAM write strobe
- ram_rdata  in  DATA_WIDTH  RAM read data; valid one cycle after the address edge
- busy  out  1  high in every state except IDLE
- grant_dma  out  1  current or last grant owner: 0 = CPU, 1 = DMA

## Operation
- States are IDLE, ACCESS, CAPTURE, ACK.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that did not win last time (round-robin).
  - On grant: latch owner into grant_dma; ram_addr/ram_wdata/ram_we <= owner's addr/wdata/we; go to ACCESS.
- ACCESS: the RAM samples its inputs at the closing edge. At that edge ram_we <= 0 and the FSM goes to CAPTURE.
- CAPTURE, at its closing edge:
  - If the owner's access was a read, owner rdata <= ram_rdata.
  - Owner ack <= 1; go to ACK.
- ACK:
  - Both req inputs are ignored.
  - At the closing edge, ack <= 0; go to IDLE.
- Requester rule: deassert req, or change to a new address/we/wdata, no later than the edge that ends the ack cycle.
- Writes leave that requester's rdata unchanged.
- Non-owner outputs stay static throughout a transaction. A request arriving mid-transaction waits.
- Reset values:
  - Outputs: cpu_ack = dma_ack = 0, cpu_rdata = dma_rdata = 0, ram_addr = 0, ram_wdata = 0, ram_we = 0, busy = 0, grant_dma = 1. With grant_dma = 1 the first contended grant goes to the CPU.
  - FSM returns to IDLE.
- Reset mid-transaction: ram_we drops immediately (asynchronously), so an in-flight write is abandoned. No ack is issued. Requesters must re-request.

## Timing
- Request sampled high in IDLE at edge t:
  - ram_we/ram_addr valid in cycle (t, t+1);
  - RAM operates at t+1;
  - ack and rdata valid in cycle (t+2, t+3);
  - IDLE again at t+3.
- Earliest next grant is at edge t+4. One access per 4 cycles; ack latency is 3 cycles from the sampling edge.
- ram_we is high for exactly one cycle per write, never during CAPTURE/ACK/IDLE.
- Under contention each requester waits at most one foreign transaction (≤ 4 cycles) before its grant.

## Structure
- A shared package holds:
  - the state enum (IDLE, ACCESS, CAPTURE, ACK), 2 bits;
  - owner constants OWN_CPU = 0, OWN_DMA = 1;
  - default ADDR_WIDTH/DATA_WIDTH constants, also used by the RAM and MDR blocks.
- No sub-module: the 2-way round-robin pick is one expression in IDLE.

## Test plan
- CPU read, addr 0x010, ram holds 0x1234ABCD -> cpu_ack high exactly one cycle, 3 edges after the sampling edge; cpu_rdata = 0x1234ABCD; dma_ack never high.
- DMA write 0xDEADBEEF to 0x1FF, then CPU read of 0x1FF -> ram_we high one cycle with ram_addr = 0x1FF; cpu_rdata = 0xDEADBEEF; dma_rdata stays 0.
- Both requests asserted together from reset, each re-requesting immediately after its ack -> grant order CPU, DMA, CPU, DMA; each ack 4 cycles after the other's.
- CPU holds back-to-back reads while DMA requests once -> DMA granted next after the current CPU transaction, latency ≤ 7 cycles from dma_req.
- Reset asserted during ACCESS of a CPU write -> ram_we = 0 immediately; no cpu_ack; RAM contents unchanged; FSM in IDLE; busy = 0.
- CPU write of 0x55 after a read returned 0x99 -> cpu_rdata stays 0x99; cpu_ack still pulses.
